adc_sample_averager: RTL and testbench



---
 rtl/adc_sample_averager.sv | 150 +++++++++++++++
 tb/tb_adc_sample_averager.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_averager.sv
// Averages 2^L signed ADC samples into one sign-extended 32-bit word; 1-cycle latency from the final accepted sample.
// Input is never stalled: samples offered while the output beat is pending are dropped and flagged. Optional macro ADC_AVG_ROUND_EN.
module adc_sample_averager #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int MAX_LOG2_AVG = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [3:0]  log2_avg,
  input  logic [15:0] packet_len,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        dropped
);

  localparam int ACC_W = SAMPLE_WIDTH + MAX_LOG2_AVG;
  localparam int CNT_W = MAX_LOG2_AVG + 1;
  localparam logic [3:0] MAX_L = 4'(MAX_LOG2_AVG);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               l_q, l_d;
  logic [15:0]              plen_q, plen_d;
  logic [15:0]              beat_q, beat_d;
  logic [31:0]              tdata_q, tdata_d;
  logic                     tlast_q, tlast_d;
  logic                     dropped_q, dropped_d;

  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  shifted;
  logic [31:0]              avg_word;
  logic [CNT_W-1:0]         last_cnt;
  logic [3:0]               l_clamped;
  logic                     unused_bits;

  assign sample_ext = ACC_W'($signed(s_axis_tdata[31 -: SAMPLE_WIDTH]));
  assign sum        = acc_q + sample_ext;
`ifdef ADC_AVG_ROUND_EN
  // Half an LSB of the result; evaluates to zero for L=0 so passthrough is exact.
  assign rnd        = (ACC_W'(1) << l_q) >> 1;
`else
  assign rnd        = '0;
`endif
  assign shifted    = (sum + rnd) >>> l_q;
  assign avg_word   = 32'($signed(shifted[SAMPLE_WIDTH-1:0]));
  assign last_cnt   = (CNT_W'(1) << l_q) - CNT_W'(1);
  assign l_clamped  = (log2_avg > MAX_L) ? MAX_L : log2_avg;
  assign unused_bits = ^{s_axis_tdata[31-SAMPLE_WIDTH:0], shifted[ACC_W-1:SAMPLE_WIDTH]};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    l_d       = l_q;
    plen_d    = plen_q;
    beat_d    = beat_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    dropped_d = dropped_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (enable) begin
          state_d   = ACCUM;
          l_d       = l_clamped;
          plen_d    = packet_len;
          acc_d     = '0;
          cnt_d     = '0;
          dropped_d = 1'b0;
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          beat_d  = '0;
        end else if (s_axis_tvalid) begin
          if (cnt_q == last_cnt) begin
            state_d = OUTPUT;
            tdata_d = avg_word;
            tlast_d = (plen_q != 16'd0) && (beat_q == plen_q - 16'd1);
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      OUTPUT: begin
        if (s_axis_tvalid) dropped_d = 1'b1;
        if (m_axis_tready) begin
          acc_d  = '0;
          cnt_d  = '0;
          beat_d = tlast_q ? 16'd0 : beat_q + 16'd1;
          if (enable) begin
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
            beat_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      l_q       <= '0;
      plen_q    <= '0;
      beat_q    <= '0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      l_q       <= l_d;
      plen_q    <= plen_d;
      beat_q    <= beat_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      dropped_q <= dropped_d;
    end
  end

  assign s_axis_tready = (state_q == ACCUM);
  assign m_axis_tvalid = (state_q == OUTPUT);
  assign m_axis_tlast  = tlast_q && (state_q == OUTPUT);
  assign m_axis_tdata  = tdata_q;
  assign dropped       = dropped_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager: table of single-average vectors plus
// hand-written sequences for packets, drops, enable/reset corner cases.
module tb_adc_sample_averager;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic [3:0]  log2_avg;
  logic [15:0] packet_len;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        dropped;

  int tests;
  int fails;

`ifdef ADC_AVG_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  adc_sample_averager dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .log2_avg      (log2_avg),
    .packet_len    (packet_len),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .dropped       (dropped)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [3:0]       l;
    logic [2:0]       n;
    logic [3:0][23:0] s;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [3:0] l, input int n, input int a, input int b,
                              input int c, input int d, input logic [31:0] e);
    vec_t v;
    v.l    = l;
    v.n    = 3'(n);
    v.s[0] = 24'(a);
    v.s[1] = 24'(b);
    v.s[2] = 24'(c);
    v.s[3] = 24'(d);
    v.exp  = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Offer one conversion word for exactly one clock; low byte is status junk.
  task automatic push(input int sample);
    s_axis_tdata  = {24'(sample), 8'hA5};
    s_axis_tvalid = 1'b1;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic start(input logic [3:0] l, input logic [15:0] plen);
    enable = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    log2_avg   = l;
    packet_len = plen;
    enable     = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic consume();
    m_axis_tready = 1'b1;
    @(posedge aclk); #1;
    m_axis_tready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    aresetn = 1'b0;
    enable = 1'b0;
    log2_avg = 4'd0;
    packet_len = 16'd0;
    s_axis_tdata = 32'd0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;

    vecs[0] = mk(4'd2, 4, 10, 20, 30, 40, 32'h0000_0019);
    vecs[1] = mk(4'd2, 4, 16, 32, 48, 64, 32'h0000_0028);
    vecs[2] = mk(4'd1, 2, -3, 0, 0, 0, RND ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
    vecs[3] = mk(4'd0, 1, 8388607, 0, 0, 0, 32'h007F_FFFF);
    vecs[4] = mk(4'd0, 1, -8388608, 0, 0, 0, 32'hFF80_0000);
    vecs[5] = mk(4'd2, 4, 8388607, 8388607, 8388607, 8388607, 32'h007F_FFFF);
    vecs[6] = mk(4'd2, 4, 1, 2, 2, 2, RND ? 32'd2 : 32'd1);
    vecs[7] = mk(4'd1, 2, 5, 6, 0, 0, RND ? 32'd6 : 32'd5);
    vecs[8] = mk(4'd2, 4, -8388608, -8388608, -8388608, -8388608, 32'hFF80_0000);
    vecs[9] = mk(4'd1, 2, -1, -2, 0, 0, RND ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);

    repeat (2) @(posedge aclk);
    #1;
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_m_tdata", m_axis_tdata, 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("idle_s_tready", 32'(s_axis_tready), 32'd0);

    for (int i = 0; i < 10; i++) begin
      start(vecs[i].l, 16'd0);
      chk($sformatf("vec%0d_accum_rdy", i), 32'(s_axis_tready), 32'd1);
      for (int k = 0; k < int'(vecs[i].n); k++) begin
        if (k == int'(vecs[i].n) - 1 && k > 0)
          chk($sformatf("vec%0d_early", i), 32'(m_axis_tvalid), 32'd0);
        push(int'($signed(vecs[i].s[k[1:0]])));
      end
      chk($sformatf("vec%0d_valid", i), 32'(m_axis_tvalid), 32'd1);
      chk($sformatf("vec%0d_data", i), m_axis_tdata, vecs[i].exp);
      chk($sformatf("vec%0d_last", i), 32'(m_axis_tlast), 32'd0);
      chk($sformatf("vec%0d_blocked", i), 32'(s_axis_tready), 32'd0);
      consume();
    end

    // Passthrough packets of 3: tlast on the 3rd and 6th beat.
    start(4'd0, 16'd3);
    for (int i = 0; i < 7; i++) begin
      push(100 + i);
      chk($sformatf("pkt%0d_valid", i), 32'(m_axis_tvalid), 32'd1);
      chk($sformatf("pkt%0d_data", i), m_axis_tdata, 32'(100 + i));
      chk($sformatf("pkt%0d_last", i), 32'(m_axis_tlast), (i == 2 || i == 5) ? 32'd1 : 32'd0);
      consume();
    end
    chk("pkt_dropped", 32'(dropped), 32'd0);

    // Samples offered while the beat is blocked are lost and flagged.
    start(4'd1, 16'd0);
    push(10);
    push(20);
    chk("drop_first", m_axis_tdata, 32'd15);
    push(1000);
    push(1000);
    chk("drop_flag", 32'(dropped), 32'd1);
    chk("drop_stable_data", m_axis_tdata, 32'd15);
    chk("drop_stable_valid", 32'(m_axis_tvalid), 32'd1);
    consume();
    push(2);
    push(4);
    chk("drop_next_avg", m_axis_tdata, 32'd3);
    chk("drop_sticky", 32'(dropped), 32'd1);
    consume();

    // Enable low mid-accumulation discards the partial sum and resets the beat count.
    start(4'd2, 16'd2);
    chk("en_restart_clr_drop", 32'(dropped), 32'd0);
    repeat (4) push(4);
    chk("en_beat0_data", m_axis_tdata, 32'd4);
    chk("en_beat0_last", 32'(m_axis_tlast), 32'd0);
    push(99);
    chk("en_drop_set", 32'(dropped), 32'd1);
    consume();
    repeat (3) push(100);
    enable = 1'b0;
    @(posedge aclk); #1;
    chk("en_idle_rdy", 32'(s_axis_tready), 32'd0);
    repeat (3) @(posedge aclk);
    #1;
    chk("en_no_beat", 32'(m_axis_tvalid), 32'd0);
    chk("en_drop_kept", 32'(dropped), 32'd1);
    start(4'd2, 16'd2);
    chk("en_reen_drop_clr", 32'(dropped), 32'd0);
    repeat (4) push(8);
    chk("en_reen_data", m_axis_tdata, 32'd8);
    chk("en_reen_last_beat0", 32'(m_axis_tlast), 32'd0);
    consume();
    repeat (4) push(8);
    chk("en_reen_last_beat1", 32'(m_axis_tlast), 32'd1);
    consume();

    // Enable low while a beat is pending: the beat still completes.
    start(4'd0, 16'd0);
    push(77);
    enable = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("eno_held_valid", 32'(m_axis_tvalid), 32'd1);
    chk("eno_held_data", m_axis_tdata, 32'd77);
    consume();
    chk("eno_done_valid", 32'(m_axis_tvalid), 32'd0);
    chk("eno_idle_rdy", 32'(s_axis_tready), 32'd0);
    push(5);
    chk("eno_idle_no_drop", 32'(dropped), 32'd0);

    // log2_avg above the maximum clamps to 8: 256 samples per output.
    start(4'd15, 16'd0);
    for (int i = 0; i < 255; i++) push(-1);
    chk("clamp_early", 32'(m_axis_tvalid), 32'd0);
    push(511);
    chk("clamp_valid", 32'(m_axis_tvalid), 32'd1);
    chk("clamp_data", m_axis_tdata, 32'd1);
    consume();

    // Asynchronous reset while a beat is pending.
    start(4'd1, 16'd1);
    push(6);
    push(2);
    chk("ar_pre_data", m_axis_tdata, 32'd4);
    chk("ar_pre_last", 32'(m_axis_tlast), 32'd1);
    push(1);
    chk("ar_pre_drop", 32'(dropped), 32'd1);
    #2;
    aresetn = 1'b0;
    enable  = 1'b0;
    #1;
    chk("ar_valid", 32'(m_axis_tvalid), 32'd0);
    chk("ar_last", 32'(m_axis_tlast), 32'd0);
    chk("ar_dropped", 32'(dropped), 32'd0);
    chk("ar_data", m_axis_tdata, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("ar_stay_idle", 32'(s_axis_tready), 32'd0);
    enable = 1'b1;
    @(posedge aclk); #1;
    chk("ar_reen_rdy", 32'(s_axis_tready), 32'd1);
    push(3);
    push(5);
    chk("ar_reen_data", m_axis_tdata, 32'd4);
    chk("ar_reen_last", 32'(m_axis_tlast), 32'd1);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
